// File: rtl/cache_dados.sv
// Direct-mapped write-through, no-write-allocate data cache for the MIPS memory stage.
// Optional read hit/miss statistics are built when CACHE_STATS_EN is defined.
module cache_dados #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              r_en,
  input  logic              w_en,
  output logic [DATA_W-1:0] saida_cache,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_MISS,
    S_WR_THRU
  } state_t;

  state_t r_state, w_next;
  logic r_armed;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic [INDEX_W-1:0] w_idx, w_fill_idx;
  logic [TAG_W-1:0] w_tag, w_fill_tag;
  logic w_rd, w_wr, w_accept, w_hit, w_fill, w_done;

  assign w_idx      = address[INDEX_W-1:0];
  assign w_tag      = address[ADDR_W-1:INDEX_W];
  assign w_fill_idx = mem_addr[INDEX_W-1:0];
  assign w_fill_tag = mem_addr[ADDR_W-1:INDEX_W];
  // both enables low counts as a read; the write is dropped
  assign w_rd     = ~r_en;
  assign w_wr     = r_en & ~w_en;
  assign w_accept = (r_state == S_IDLE) & r_armed & (w_rd | w_wr);
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_fill   = (r_state == S_RD_MISS) & mem_ack;
  assign w_done   = (r_state != S_IDLE) & mem_ack;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_wr)
          w_next = S_WR_THRU;
        else if (w_accept && !w_hit)
          w_next = S_RD_MISS;
      end
      S_RD_MISS: if (mem_ack) w_next = S_IDLE;
      S_WR_THRU: if (mem_ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // a held-low enable must see both enables high before another access
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_armed <= 1'b1;
    else if (r_en && w_en) r_armed <= 1'b1;
    else if (w_accept)     r_armed <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      saida_cache <= '0;
      stall       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else if (w_accept) begin
      if (w_rd && w_hit) begin
        saida_cache <= r_data[w_idx];
      end else begin
        stall    <= 1'b1;
        mem_req  <= 1'b1;
        mem_we   <= w_wr;
        mem_addr <= address;
        if (w_wr) mem_wdata <= data;
      end
    end else if (w_done) begin
      stall   <= 1'b0;
      mem_req <= 1'b0;
      if (r_state == S_RD_MISS) saida_cache <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_valid <= '0;
    else if (w_fill) r_valid[w_fill_idx] <= 1'b1;
  end

  // tag and data storage carry no reset; valid bits gate them
  always_ff @(posedge clk) begin
    if (!reset && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_rdata;
    end else if (!reset && w_accept && w_wr && w_hit) begin
      r_data[w_idx] <= data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hits, r_misses;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_accept && w_rd) begin
      if (w_hit) begin
        if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
      end else begin
        if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
      end
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_dados.sv
// Randomized bench for cache_dados against an address-level cache/memory model.
// Compile with CACHE_STATS_EN defined to also check the statistics counters.
module tb_cache_dados;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address = '0;
  logic [31:0] data = '0;
  logic        r_en = 1'b1;
  logic        w_en = 1'b1;
  logic [31:0] saida_cache;
  logic        stall, mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_count, miss_count;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  cache_dados dut (
    .clk(clk), .reset(reset), .address(address), .data(data),
    .r_en(r_en), .w_en(w_en), .saida_cache(saida_cache),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // memory seen by the DUT, and the independent expectation of its contents
  logic [31:0] mem_model [4096];
  logic [31:0] exp_mem [4096];
  // cache model: which full address each line currently holds
  bit          mv [16];
  logic [11:0] maddr [16];
  int exp_hits = 0;
  int exp_misses = 0;

  int ack_delay = 0;
  int wait_cnt = 0;
  int req_pulses = 0;
  bit prev_req = 1'b0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && !prev_req) req_pulses++;
    prev_req = mem_req;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else        mem_rdata = mem_model[mem_addr];
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic settle();
    int k = 0;
    while (stall && k < 64) begin k++; @(negedge clk); end
  endtask

  task automatic check_stats();
    check("hit_count", hit_count, STATS ? exp_hits : 0);
    check("miss_count", miss_count, STATS ? exp_misses : 0);
  endtask

  task automatic do_read(input logic [11:0] a, input bit both_low,
                         input int dly);
    int cnt;
    bit hit;
    hit = mv[a[3:0]] && maddr[a[3:0]] == a;
    ack_delay = dly;
    address = a;
    r_en = 1'b0;
    if (both_low) begin w_en = 1'b0; data = $urandom; end
    @(negedge clk);
    r_en = 1'b1;
    w_en = 1'b1;
    if (hit) begin
      check("rd_hit_stall", stall, 0);
      check("rd_hit_req", mem_req, 0);
      check("rd_hit_data", saida_cache, exp_mem[a]);
      exp_hits++;
    end else begin
      check("rd_miss_req", mem_req, 1);
      check("rd_miss_we", mem_we, 0);
      check("rd_miss_addr", mem_addr, a);
      cnt = 0;
      while (stall && cnt < 64) begin cnt++; @(negedge clk); end
      check("rd_stall_cycles", cnt, dly + 1);
      check("rd_req_drop", mem_req, 0);
      check("rd_miss_data", saida_cache, exp_mem[a]);
      mv[a[3:0]] = 1'b1;
      maddr[a[3:0]] = a;
      exp_misses++;
    end
    check_stats();
    settle();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input int dly, input int hold);
    int cnt, p0;
    ack_delay = dly;
    p0 = req_pulses;
    address = a;
    data = d;
    r_en = 1'b1;
    w_en = 1'b0;
    @(negedge clk);
    check("wr_req", mem_req, 1);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, a);
    check("wr_wdata", mem_wdata, d);
    cnt = 0;
    while (stall && cnt < 64) begin cnt++; @(negedge clk); end
    check("wr_stall_cycles", cnt, dly + 1);
    check("wr_req_drop", mem_req, 0);
    for (int i = cnt + 1; i < hold; i++) @(negedge clk);
    w_en = 1'b1;
    data = $urandom;
    repeat (2) @(negedge clk);
    check("wr_req_pulses", req_pulses - p0, 1);
    exp_mem[a] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  initial begin
    logic [31:0] v;
    logic [11:0] a;
    int op;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom;
      mem_model[i] = v;
      exp_mem[i] = v;
    end
    mem_model[12'h013] = 32'hDEADBEEF;
    exp_mem[12'h013]   = 32'hDEADBEEF;
    mem_model[12'h023] = 32'h11111111;
    exp_mem[12'h023]   = 32'h11111111;
    model_reset();

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_saida", saida_cache, 0);
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check_stats();

    do_read(12'h013, 1'b0, 3);
    do_read(12'h013, 1'b0, 0);
    do_read(12'h023, 1'b0, 2);
    do_read(12'h013, 1'b0, 1);
    do_write(12'h013, 32'hCAFEF00D, 2, 1);
    do_read(12'h013, 1'b0, 0);
    do_write(12'h0A5, 32'h12345678, 1, 10);
    do_read(12'h0A5, 1'b0, 0);
    do_read(12'h0A5, 1'b1, 1);

    ack_delay = 6;
    address = 12'h0F7;
    r_en = 1'b0;
    @(negedge clk);
    r_en = 1'b1;
    check("abort_req_pre", mem_req, 1);
    reset = 1'b1;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_stats();
    do_read(12'h013, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      a = {6'd0, 2'($urandom_range(0, 3)), 4'($urandom)};
      op = $urandom_range(0, 9);
      if (op < 5)       do_read(a, 1'b0, $urandom_range(0, 3));
      else if (op == 5) do_read(a, 1'b1, $urandom_range(0, 3));
      else do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_dados.md
# cache_dados

Direct-mapped, write-through, no-write-allocate data cache between the multicycle MIPS core's memory stage and main data memory. It consumes the core's word address, write data and active-low read/write enables, and returns read data on `saida_cache`. It holds the core in its memory stage via `stall` while a miss fill or write-through is outstanding on the memory-side request/acknowledge handshake.

## Interface
- `ADDR_W`, 12: word-address width from the core.
- `DATA_W`, 32: data word width.
- `INDEX_W`, 4: line index bits; 2^INDEX_W one-word lines. Tag = `ADDR_W-INDEX_W` bits.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `address` in ADDR_W: core word address; index = `[INDEX_W-1:0]`, tag = `[ADDR_W-1:INDEX_W]`.
- `data` in DATA_W: store data from the core.
- `r_en` in 1: active-low read request.
- `w_en` in 1: active-low write request.
- `saida_cache` out DATA_W: read data returned to the core.
- `stall` out 1: high while a request is outstanding.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out ADDR_W: memory word address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data; valid in the `mem_ack` cycle.
- `mem_ack` in 1: one-cycle completion pulse.
- `hit_count` out 16: read-hit counter (see Configuration).
- `miss_count` out 16: read-miss counter (see Configuration).

## Operation
- Storage per line: valid bit, tag, data word. Valid bits clear on reset only. Tag and data are not reset.
- Arming flag `armed` (reset 1):
  - A request is accepted only in IDLE with `armed`=1.
  - Acceptance clears `armed`.
  - `armed` sets on any cycle in which both `r_en` and `w_en` are high.
  - A held-low enable therefore never produces a duplicate access.
- If both enables are low in the same cycle, the request is treated as a read. The write is dropped.
- FSM states: IDLE, RD_MISS, WR_THRU.
  - IDLE, read hit (valid and tag match): `saida_cache` <= line data. Stay in IDLE; `stall` stays 0.
  - IDLE, read miss: `stall`<=1, `mem_req`<=1, `mem_we`<=0, `mem_addr`<=`address`; go to RD_MISS.
  - IDLE, write: on hit, line data <= `data`. On miss, the line is unchanged. In both cases `stall`<=1, `mem_req`<=1, `mem_we`<=1, `mem_addr`<=`address`, `mem_wdata`<=`data`; go to WR_THRU.
  - RD_MISS, `mem_ack`=1: line valid<=1, tag<=latched tag, data<=`mem_rdata`. `saida_cache`<=`mem_rdata`, `mem_req`<=0, `stall`<=0; go to IDLE.
  - WR_THRU, `mem_ack`=1: `mem_req`<=0, `stall`<=0; go to IDLE.
- Address and data are latched at acceptance. Core inputs are ignored outside IDLE.
- `mem_ack` is ignored in IDLE.
- Reset values: `saida_cache`=0, `stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, counters=0, state IDLE.
- Reset asserted mid-transaction aborts it immediately. `mem_req` and `stall` drop asynchronously, no line is updated, and all valid bits clear.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Read hit: request accepted at edge N; `saida_cache` valid after edge N. `stall` is never asserted.
- Read miss: `stall` and `mem_req` rise after the accept edge N. With `mem_ack` sampled at edge M, `saida_cache` is valid and `stall`/`mem_req` are low after edge M. Minimum total stall is one cycle, with `mem_ack` arriving the cycle after `mem_req` rises.
- Write: same timing as a read miss. The hit-line update is visible to a read accepted at edge N+2 or later.
- Back-to-back requests need one cycle with both enables high between them to re-arm.
- `mem_req` stays high until `mem_ack`, with no timeout.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each accepted read hit.
  - `miss_count` increments on each accepted read miss.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- `CACHE_STATS_EN` undefined: the counter logic is absent and both ports are tied to 0.

## Test plan
- Cold read miss:
  - Stimulus: after reset, read address 0x013. Memory acks 3 cycles after `mem_req` with 0xDEADBEEF.
  - Required: `mem_req`=1, `mem_we`=0, `mem_addr`=0x013. `stall` high for 4 cycles, then `saida_cache`=0xDEADBEEF.
- Read hit:
  - Stimulus: re-read 0x013 after a cycle with both enables high.
  - Required: `saida_cache`=0xDEADBEEF the next cycle. `stall` and `mem_req` stay 0. With `CACHE_STATS_EN`, `hit_count`=1 and `miss_count`=1.
- Conflict eviction:
  - Stimulus: read 0x023 (same index 3, tag 0x02); memory returns 0x11111111. Then read 0x013.
  - Required: both reads miss; the second issues `mem_addr`=0x013.
- Write-through hit:
  - Stimulus: write 0xCAFEF00D to a cached address.
  - Required: `mem_we`=1 with matching `mem_addr`/`mem_wdata`, and `stall` until `mem_ack`. A subsequent read hits and returns 0xCAFEF00D with no `mem_req`.
- Held enable and write miss:
  - Stimulus: hold `w_en` low for 10 cycles to an uncached address.
  - Required: exactly one `mem_req` pulse sequence. A later read of that address misses (no allocate).
- Reset mid-miss:
  - Stimulus: assert `reset` while in RD_MISS.
  - Required: `mem_req`=0 and `stall`=0 immediately. The previously cached 0x013 now misses.
